dmem_port_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: the pipeline MEM stage (port P) and a debug/loader port (port D).
- Port P has priority. Port D uses a valid/ready handshake and gets a bounded-wait guarantee from a starvation counter and a 3-state grant FSM.
- Sits between the MEM stage and the data memory; drives the memory's MemRd/MemWr_final/Address/Data_in and consumes its combinational Data_out.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_port_arbiter_if.sv | 55 +++++
 rtl/dmem_port_arbiter_wait_counter.sv | 31 +++
 rtl/dmem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// ADDR_LIMIT_DEFAULT and addr_bad() only matter when DMEM_ARB_ADDR_CHECK_EN is defined.
package dmem_arb_pkg;

   localparam int DATA_W             = 32;
   localparam int ADDR_W             = 32;
   localparam int MAX_WAIT_DEFAULT   = 4;
   localparam int ADDR_LIMIT_DEFAULT = 256;

   typedef enum logic [1:0] {
      ST_PIPE    = 2'd0,
      ST_DBG     = 2'd1,
      ST_RECOVER = 2'd2
   } arb_state_e;

   // An access is illegal when it is beyond the implemented memory or not word aligned.
   function automatic logic addr_bad(input logic [ADDR_W-1:0] addr, input int unsigned limit);
      return (addr >= ADDR_W'(limit)) || (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundles the pipeline, debug and memory-side signals of the arbiter.
// addr_err exists only when DMEM_ARB_ADDR_CHECK_EN is defined.
interface dmem_port_arbiter_if;
   import dmem_arb_pkg::*;

   logic              p_rd;
   logic              p_wr;
   logic [ADDR_W-1:0] p_addr;
   logic [DATA_W-1:0] p_wdata;
   logic [DATA_W-1:0] p_rdata;
   logic              p_stall;

   logic              d_valid;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ready;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_rd;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
`ifdef DMEM_ARB_ADDR_CHECK_EN
   logic              addr_err;
`endif

   // The arbiter itself sits on the slave side of this bundle.
   modport slave (
      input  p_rd, p_wr, p_addr, p_wdata,
      input  d_valid, d_we, d_addr, d_wdata,
      input  mem_rdata,
      output p_rdata, p_stall,
      output d_ready, d_rvalid, d_rdata,
      output mem_rd, mem_wr, mem_addr, mem_wdata
`ifdef DMEM_ARB_ADDR_CHECK_EN
      , output addr_err
`endif
   );

   modport master (
      output p_rd, p_wr, p_addr, p_wdata,
      output d_valid, d_we, d_addr, d_wdata,
      output mem_rdata,
      input  p_rdata, p_stall,
      input  d_ready, d_rvalid, d_rdata,
      input  mem_rd, mem_wr, mem_addr, mem_wdata
`ifdef DMEM_ARB_ADDR_CHECK_EN
      , input addr_err
`endif
   );

endinterface

// File: rtl/dmem_port_arbiter_wait_counter.sv
// Starvation counter for the debug port: counts cycles D is blocked by P and flags
// the blocked cycle that should trigger a forced grant on the following cycle.
module arb_wait_counter #(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic hit
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0] wait_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (clr) begin
         wait_cnt <= '0;
      end else if (inc && (wait_cnt != CNT_W'(MAX_WAIT))) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   // Fires on the blocked cycle whose increment brings the count to MAX_WAIT-1,
   // so D is force-granted on its MAX_WAIT-th cycle of waiting.
   assign hit = inc && ((32'(wait_cnt) + 32'd1) >= 32'(MAX_WAIT - 1));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the pipeline (priority) and the debug port.
// Define DMEM_ARB_ADDR_CHECK_EN to suppress out-of-range/misaligned accesses and pulse addr_err.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEFAULT
`ifdef DMEM_ARB_ADDR_CHECK_EN
   , parameter int ADDR_LIMIT = ADDR_LIMIT_DEFAULT
`endif
) (
   input logic                clk,
   input logic                rst_n,
   dmem_port_arbiter_if.slave bus
);

   arb_state_e        state;
   arb_state_e        state_nxt;
   logic              p_req;
   logic              grant_p;
   logic              grant_d;
   logic              d_ready;
   logic              d_hs;
   logic              d_rd_hs;
   logic              cnt_inc;
   logic              cnt_clr;
   logic              cnt_hit;
   logic              issue_rd;
   logic              issue_wr;
   logic              issue_bad;
   logic [ADDR_W-1:0] issue_addr;
   logic [DATA_W-1:0] issue_wdata;
   logic [DATA_W-1:0] p_rdata;
   logic              d_rvalid_q;
   logic [DATA_W-1:0] d_rdata_q;

   assign p_req   = bus.p_rd | bus.p_wr;
   assign d_hs    = bus.d_valid & d_ready;
   assign d_rd_hs = d_hs & ~bus.d_we;

   // D only accumulates wait time while it is actually being pushed aside in normal mode.
   assign cnt_inc = (state == ST_PIPE) & bus.d_valid & p_req;
   assign cnt_clr = ~bus.d_valid | d_hs | (state == ST_DBG);

   arb_wait_counter #(
      .MAX_WAIT(MAX_WAIT)
   ) u_wait_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (cnt_clr),
      .inc  (cnt_inc),
      .hit  (cnt_hit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_PIPE;
      end else begin
         state <= state_nxt;
      end
   end

   // A forced debug grant is always followed by one recover cycle before normal priority resumes.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_PIPE:    if (cnt_hit) state_nxt = ST_DBG;
         ST_DBG:     state_nxt = ST_RECOVER;
         ST_RECOVER: state_nxt = ST_PIPE;
         default:    state_nxt = ST_PIPE;
      endcase
   end

   always_comb begin
      grant_p = 1'b0;
      grant_d = 1'b0;
      d_ready = 1'b0;
      case (state)
         ST_PIPE: begin
            grant_p = p_req;
            grant_d = ~p_req & bus.d_valid;
            d_ready = ~p_req & bus.d_valid;
         end
         ST_DBG: begin
            grant_d = 1'b1;
            d_ready = 1'b1;
         end
         ST_RECOVER: begin
            grant_p = p_req;
         end
         default: begin
            grant_p = 1'b0;
         end
      endcase
   end

   // Only a granted port with a live request reaches the memory; everything else reads as zero.
   always_comb begin
      issue_rd    = 1'b0;
      issue_wr    = 1'b0;
      issue_addr  = '0;
      issue_wdata = '0;
      p_rdata     = '0;
      if (grant_p) begin
         issue_wr    = bus.p_wr;
         issue_rd    = bus.p_rd & ~bus.p_wr;
         issue_addr  = bus.p_addr;
         issue_wdata = bus.p_wdata;
         if (bus.p_rd) begin
            p_rdata = bus.mem_rdata;
         end
      end else if (grant_d && bus.d_valid) begin
         issue_wr    = bus.d_we;
         issue_rd    = ~bus.d_we;
         issue_addr  = bus.d_addr;
         issue_wdata = bus.d_wdata;
      end
   end

`ifdef DMEM_ARB_ADDR_CHECK_EN
   logic addr_err_q;

   assign issue_bad = (grant_p | (grant_d & bus.d_valid)) & addr_bad(issue_addr, ADDR_LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_err_q <= 1'b0;
      end else begin
         addr_err_q <= issue_bad;
      end
   end

   assign bus.addr_err = addr_err_q;
`else
   assign issue_bad = 1'b0;
`endif

   // Debug read data is captured at the handshake edge and presented for exactly one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_rvalid_q <= 1'b0;
         d_rdata_q  <= '0;
      end else begin
         d_rvalid_q <= d_rd_hs;
         if (d_rd_hs) begin
            d_rdata_q <= issue_bad ? '0 : bus.mem_rdata;
         end
      end
   end

   assign bus.mem_rd    = issue_rd & ~issue_bad;
   assign bus.mem_wr    = issue_wr & ~issue_bad;
   assign bus.mem_addr  = issue_addr;
   assign bus.mem_wdata = issue_wdata;
   assign bus.p_rdata   = p_rdata;
   assign bus.p_stall   = p_req & ~grant_p;
   assign bus.d_ready   = d_ready;
   assign bus.d_rvalid  = d_rvalid_q;
   assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: a behavioural arbitration model predicts every
// cycle's outputs, a monitor compares them. Honours DMEM_ARB_ADDR_CHECK_EN when defined.
module tb_dmem_port_arbiter;
   import dmem_arb_pkg::*;

   localparam int MAX_WAIT     = 4;
   localparam int STARVE_LIMIT = (MAX_WAIT > 1) ? MAX_WAIT - 1 : 1;
`ifdef DMEM_ARB_ADDR_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   typedef struct packed {
      logic        d_ready;
      logic        p_stall;
      logic        mem_rd;
      logic        mem_wr;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [31:0] p_rdata;
      logic        d_rvalid;
      logic [31:0] d_rdata;
      logic        addr_err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   dmem_port_arbiter_if bus ();
   logic [31:0] env_mem [64];
   exp_t cyc_q [$];
   int checks = 0;
   int failures = 0;

   logic [31:0] ref_mem [64];
   int          waited, nx_waited;
   bit          forced, cooldown, rv_pend, err_pend;
   bit          nx_forced, nx_cooldown, nx_rv_pend, nx_err_pend, nx_wr;
   logic [31:0] rv_data, nx_rv_data, nx_wdata;
   logic [5:0]  nx_widx;

   dmem_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Environment memory: combinational read, write on the rising edge, word index from bits [7:2].
   assign bus.mem_rdata = env_mem[bus.mem_addr[7:2]];
   always @(posedge clk) begin
      if (bus.mem_wr) env_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
   end

   initial begin
      for (int i = 0; i < 64; i++) env_mem[i] = 32'(4 * i - 1);
   end

   task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic driveIdle();
      bus.p_rd = 0; bus.p_wr = 0; bus.p_addr = '0; bus.p_wdata = '0;
      bus.d_valid = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
   endtask

   task automatic modelReset();
      waited = 0; forced = 0; cooldown = 0; rv_pend = 0; err_pend = 0; rv_data = '0;
   endtask

   // P wins unless D has been pushed aside STARVE_LIMIT cycles in a row; then D owns the
   // next cycle outright and P gets the one after that to itself.
   task automatic predict(input bit prd, input bit pwr, input logic [31:0] paddr, input logic [31:0] pwdata,
                          input bit dv, input bit dwe, input logic [31:0] daddr, input logic [31:0] dwdata);
      exp_t e;
      logic [31:0] addr, wdata;
      bit rd, wr, p_wins, d_wins, preq, bad, blocked;
      bus.p_rd = prd; bus.p_wr = pwr; bus.p_addr = paddr; bus.p_wdata = pwdata;
      bus.d_valid = dv; bus.d_we = dwe; bus.d_addr = daddr; bus.d_wdata = dwdata;
      e = '0; addr = '0; wdata = '0; rd = 0; wr = 0; p_wins = 0; d_wins = 0;
      preq = prd | pwr;
      e.d_rvalid = rv_pend;
      e.d_rdata  = rv_pend ? rv_data : '0;
      e.addr_err = err_pend;
      if (forced) begin
         d_wins = dv; e.d_ready = 1; e.p_stall = preq;
      end else if (cooldown) begin
         p_wins = preq;
      end else if (preq) begin
         p_wins = 1;
      end else if (dv) begin
         d_wins = 1; e.d_ready = 1;
      end
      if (p_wins) begin
         addr = paddr; wdata = pwdata; wr = pwr; rd = prd && !pwr;
         if (prd) e.p_rdata = ref_mem[paddr[7:2]];
      end
      if (d_wins) begin
         addr = daddr; wdata = dwdata; wr = dwe; rd = !dwe;
      end
      bad = CHECK_EN && (p_wins || d_wins) && ((addr >= 32'd256) || (addr[1:0] != 2'b00));
      e.mem_rd = rd && !bad; e.mem_wr = wr && !bad; e.mem_addr = addr; e.mem_wdata = wdata;
      cyc_q.push_back(e);
      nx_rv_pend = d_wins && !dwe;
      nx_rv_data = bad ? '0 : ref_mem[addr[7:2]];
      nx_err_pend = bad;
      nx_wr = e.mem_wr; nx_widx = addr[7:2]; nx_wdata = wdata;
      blocked = !forced && !cooldown && preq && dv;
      nx_forced = 0; nx_cooldown = forced; nx_waited = 0;
      if (blocked) begin
         nx_waited = waited + 1;
         if (nx_waited >= STARVE_LIMIT) begin
            nx_forced = 1; nx_waited = 0;
         end
      end
   endtask

   task automatic commitModel();
      waited = nx_waited; forced = nx_forced; cooldown = nx_cooldown;
      rv_pend = nx_rv_pend; rv_data = nx_rv_data; err_pend = nx_err_pend;
      if (nx_wr) ref_mem[nx_widx] = nx_wdata;
   endtask

   task automatic applyStimulus(input bit prd, input bit pwr, input logic [31:0] paddr, input logic [31:0] pwdata,
                                input bit dv, input bit dwe, input logic [31:0] daddr, input logic [31:0] dwdata);
      predict(prd, pwr, paddr, pwdata, dv, dwe, daddr, dwdata);
      commitModel();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset(input int cycles);
      driveIdle();
      rst_n = 0;
      modelReset();
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_d_rvalid", bus.d_rvalid, 0);
      checkOutput("reset_d_rdata", bus.d_rdata, 0);
      checkOutput("reset_d_ready", bus.d_ready, 0);
      checkOutput("reset_p_stall", bus.p_stall, 0);
      checkOutput("reset_mem_strobes", {bus.mem_rd, bus.mem_wr}, 0);
      checkOutput("reset_mem_addr", bus.mem_addr, 0);
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   function automatic logic [31:0] genAddr();
      if (CHECK_EN && ($urandom_range(0, 7) == 0)) begin
         return ($urandom_range(0, 1) == 0) ? (32'h100 + 32'($urandom_range(0, 63)) * 4)
                                            : (32'($urandom_range(0, 63)) * 4 + 32'd1);
      end
      return 32'($urandom_range(0, 63)) * 4;
   endfunction

   // Monitor: one expectation per driven cycle, compared away from the rising edge.
   initial begin
      int   cyc;
      exp_t e;
      exp_t a;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (cyc_q.size() != 0) begin
            e = cyc_q.pop_front();
            a.d_ready   = bus.d_ready;
            a.p_stall   = bus.p_stall;
            a.mem_rd    = bus.mem_rd;
            a.mem_wr    = bus.mem_wr;
            a.mem_addr  = bus.mem_addr;
            a.mem_wdata = bus.mem_wdata;
            a.p_rdata   = bus.p_rdata;
            a.d_rvalid  = bus.d_rvalid;
            a.d_rdata   = bus.d_rvalid ? bus.d_rdata : '0;
`ifdef DMEM_ARB_ADDR_CHECK_EN
            a.addr_err  = bus.addr_err;
`else
            a.addr_err  = 1'b0;
`endif
            checkOutput($sformatf("cycle%0d", cyc), a, e);
         end
         cyc++;
      end
   end

   initial begin
      bit          prd, pwr, dv, dwe;
      logic [31:0] paddr, daddr;
      int          p_pct;
      rst_n = 0;
      driveIdle();
      for (int i = 0; i < 64; i++) ref_mem[i] = 32'(4 * i - 1);
      doReset(2);

      // Directed: debug read, pipeline load, starvation, write-then-read.
      applyStimulus(0, 0, 0, 0, 1, 0, 32'd4, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 32'd8, 32'h0, 0, 0, 0, 0);
      for (int i = 0; i < 2 * MAX_WAIT + 2; i++)
         applyStimulus(0, 1, 32'(i * 4 + 16), $urandom, 1, 1, 32'h40, 32'h1234_0000 + 32'(i));
      applyStimulus(0, 0, 0, 0, 1, 1, 32'd12, 32'hDEAD_BEEF);
      applyStimulus(1, 0, 32'd12, 32'h0, 0, 0, 0, 0);

      // Reset lands between a debug read handshake and its response cycle.
      predict(0, 0, 0, 0, 1, 0, 32'd8, 32'h0);
      @(negedge clk);
      #2;
      rst_n = 0;
      modelReset();
      @(posedge clk);
      @(negedge clk);
      checkOutput("midreset_d_rvalid", bus.d_rvalid, 0);
      driveIdle();
      @(posedge clk);
      #1;
      rst_n = 1;
      for (int i = 0; i < MAX_WAIT + 2; i++)
         applyStimulus(1, 0, 32'd8, 32'h0, 1, 0, 32'd4, 32'h0);

`ifdef DMEM_ARB_ADDR_CHECK_EN
      applyStimulus(0, 1, 32'h104, 32'hBAD0_BAD0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 32'd4, 32'h0, 0, 0, 0, 0);
`endif

      // Random traffic, second half with a much busier pipeline to provoke forced grants.
      for (int i = 0; i < 400; i++) begin
         p_pct = (i < 200) ? 40 : 85;
         prd = 0; pwr = 0;
         if ($urandom_range(0, 99) < p_pct) begin
            case ($urandom_range(0, 2))
               0:       prd = 1;
               1:       pwr = 1;
               default: begin prd = 1; pwr = 1; end
            endcase
         end
         dv = ($urandom_range(0, 4) != 0);
         dwe = ($urandom_range(0, 1) == 1);
         paddr = genAddr();
         daddr = genAddr();
         applyStimulus(prd, pwr, paddr, $urandom, dv, dwe, daddr, $urandom);
      end
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

      checkOutput("scoreboard_drain", cyc_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
